// File: rtl/button_pkg.sv
// rtl/button_pkg.sv - shared constants and hold-FSM state type for the button conditioner
package button_pkg;

  localparam int DEBOUNCE_CYCLES = 120000;
  localparam int LONG_CYCLES     = 6000000;
  localparam int REPEAT_CYCLES   = 1200000;

  typedef enum logic [1:0] {
    IDLE,
    HOLD,
    REPEAT
  } hold_state_t;

endpackage

// File: rtl/button_debounce_chan.sv
// rtl/button_debounce_chan.sv - one channel: 2-flop sync, stable-interval debounce, edge pulses
// Hold/auto-repeat FSM is built only when BUTTON_DEBOUNCE_LONGPRESS_EN is defined.
module button_debounce_chan #(
  parameter int DEBOUNCE_CYCLES = button_pkg::DEBOUNCE_CYCLES,
  parameter int LONG_CYCLES     = button_pkg::LONG_CYCLES,
  parameter int REPEAT_CYCLES   = button_pkg::REPEAT_CYCLES
) (
  input  logic CLK,
  input  logic RST,
  input  logic btn_raw,
  output logic btn_level,
  output logic btn_press,
  output logic btn_release,
  output logic btn_long,
  output logic btn_repeat
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);

  logic             r_s1;
  logic             r_s2;
  logic             r_level;
  logic             r_press;
  logic             r_release;
  logic [CNT_W-1:0] r_cnt;
  logic             w_accept;
  logic             w_fall;

  assign w_accept = (r_s2 != r_level) && (r_cnt == CNT_W'(DEBOUNCE_CYCLES - 1));
  assign w_fall   = w_accept && r_level;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_s1      <= 1'b0;
      r_s2      <= 1'b0;
      r_level   <= 1'b0;
      r_press   <= 1'b0;
      r_release <= 1'b0;
      r_cnt     <= '0;
    end else begin
      r_s1      <= btn_raw;
      r_s2      <= r_s1;
      r_press   <= w_accept && r_s2;
      r_release <= w_accept && !r_s2;
      if (r_s2 == r_level) begin
        r_cnt <= '0;
      end else if (w_accept) begin
        r_level <= r_s2;
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign btn_level   = r_level;
  assign btn_press   = r_press;
  assign btn_release = r_release;

`ifdef BUTTON_DEBOUNCE_LONGPRESS_EN
  localparam int HMAX   = (LONG_CYCLES > REPEAT_CYCLES) ? LONG_CYCLES : REPEAT_CYCLES;
  localparam int HCNT_W = $clog2(HMAX + 1);

  button_pkg::hold_state_t r_state;
  button_pkg::hold_state_t w_state_nxt;
  logic [HCNT_W-1:0]       r_hcnt;
  logic [HCNT_W-1:0]       w_hcnt_nxt;
  logic                    w_long_hit;
  logic                    w_rep_hit;
  logic                    r_long;
  logic                    r_repeat;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state  <= button_pkg::IDLE;
      r_hcnt   <= '0;
      r_long   <= 1'b0;
      r_repeat <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_hcnt   <= w_hcnt_nxt;
      r_long   <= w_long_hit;
      r_repeat <= w_rep_hit;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_hcnt_nxt  = r_hcnt;
    if (!r_level) begin
      w_state_nxt = button_pkg::IDLE;
      w_hcnt_nxt  = '0;
    end else begin
      unique case (r_state)
        button_pkg::IDLE: begin
          w_state_nxt = button_pkg::HOLD;
          w_hcnt_nxt  = HCNT_W'(1);
        end
        button_pkg::HOLD: begin
          if (r_hcnt == HCNT_W'(LONG_CYCLES - 1)) begin
            w_state_nxt = button_pkg::REPEAT;
            w_hcnt_nxt  = '0;
          end else begin
            w_hcnt_nxt = r_hcnt + 1'b1;
          end
        end
        button_pkg::REPEAT: begin
          if (r_hcnt == HCNT_W'(REPEAT_CYCLES - 1)) w_hcnt_nxt = '0;
          else                                      w_hcnt_nxt = r_hcnt + 1'b1;
        end
        default: begin
          w_state_nxt = button_pkg::IDLE;
          w_hcnt_nxt  = '0;
        end
      endcase
    end
  end

  // A release accepted this cycle suppresses hold pulses so pulses stay exclusive.
  always_comb begin
    w_long_hit = 1'b0;
    w_rep_hit  = 1'b0;
    if (r_level && !w_fall) begin
      w_long_hit = (r_state == button_pkg::HOLD)   && (r_hcnt == HCNT_W'(LONG_CYCLES - 1));
      w_rep_hit  = (r_state == button_pkg::REPEAT) && (r_hcnt == HCNT_W'(REPEAT_CYCLES - 1));
    end
  end

  assign btn_long   = r_long;
  assign btn_repeat = r_repeat;
`else
  logic w_unused_cfg;
  assign w_unused_cfg = ^{LONG_CYCLES, REPEAT_CYCLES};
  assign btn_long     = 1'b0;
  assign btn_repeat   = 1'b0;
`endif

endmodule

// File: rtl/button_debounce.sv
// rtl/button_debounce.sv - NUM_BTNS independent debounced button channels
// Long-press/auto-repeat outputs are live only with BUTTON_DEBOUNCE_LONGPRESS_EN.
module button_debounce #(
  parameter int NUM_BTNS        = 4,
  parameter int DEBOUNCE_CYCLES = button_pkg::DEBOUNCE_CYCLES,
  parameter int LONG_CYCLES     = button_pkg::LONG_CYCLES,
  parameter int REPEAT_CYCLES   = button_pkg::REPEAT_CYCLES
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic [NUM_BTNS-1:0] btn_raw,
  output logic [NUM_BTNS-1:0] btn_level,
  output logic [NUM_BTNS-1:0] btn_press,
  output logic [NUM_BTNS-1:0] btn_release,
  output logic [NUM_BTNS-1:0] btn_long,
  output logic [NUM_BTNS-1:0] btn_repeat
);

  for (genvar g = 0; g < NUM_BTNS; g++) begin : g_chan
    button_debounce_chan #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .LONG_CYCLES    (LONG_CYCLES),
      .REPEAT_CYCLES  (REPEAT_CYCLES)
    ) u_chan (
      .CLK        (CLK),
      .RST        (RST),
      .btn_raw    (btn_raw[g]),
      .btn_level  (btn_level[g]),
      .btn_press  (btn_press[g]),
      .btn_release(btn_release[g]),
      .btn_long   (btn_long[g]),
      .btn_repeat (btn_repeat[g])
    );
  end

endmodule
